// File: rtl/stack_ctrl.sv
// stack_ctrl: multi-cycle sequencer for PUSH/POP/CALL/RET on a full-descending
// stack that grows downward in 4-byte words. It reads SP from the register
// bank, bounds-checks it, performs one data-memory access with a ready
// handshake and an abort timeout, then commits the new SP. For POP it also
// writes the popped value to the destination register.
module stack_ctrl #(
    parameter logic [31:0] STACK_TOP   = 32'h0000_0100,
    parameter logic [31:0] STACK_LIMIT = 32'h0000_00F0,
    parameter int          MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] data_in,
    input  logic [4:0]  dst,
    input  logic [31:0] sp_in,
    output logic        readSP,
    output logic        writeSP,
    output logic [31:0] write_dataSP,
    output logic        writeReg,
    output logic [4:0]  dr,
    output logic [31:0] write_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic        pc_load,
    output logic [31:0] data_out,
    output logic [1:0]  err_code
);

    localparam logic [1:0] OP_POP = 2'b01;
    localparam logic [1:0] OP_RET = 2'b11;

    localparam logic [1:0] ERR_OK        = 2'b00;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b11;

    // The counter only has to reach MEM_TIMEOUT-1; the cycle that would make
    // it MEM_TIMEOUT is the one that aborts.
    localparam int             CW        = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0]  TMO_LAST  = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_SP,
        CHECK,
        MEM,
        WR_SP,
        DONE,
        ERR
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [1:0]    op_q;
    logic [31:0]   data_q;
    logic [4:0]    dst_q;
    logic [31:0]   sp_q;
    logic [31:0]   new_sp_q;
    logic [31:0]   addr_q;
    logic [CW-1:0] tmo_cnt;

    logic          push_like;
    logic          is_pop;
    logic          is_ret;
    logic          overflow;
    logic          underflow;
    logic          tmo_hit;

    // PUSH and CALL both write memory; POP and RET both read it (op[0]=1).
    assign push_like = ~op_q[0];
    assign is_pop    = (op_q == OP_POP);
    assign is_ret    = (op_q == OP_RET);

    // Compared on the unwrapped SP so that SP values near zero read as
    // overflow rather than wrapping to a huge legal-looking address.
    assign overflow  = (sp_q < (STACK_LIMIT + 32'd4));
    assign underflow = (sp_q >= STACK_TOP);
    assign tmo_hit   = (tmo_cnt == TMO_LAST);

    // State register; reset drops any in-flight request immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers: operation capture, SP snapshot, bounds result,
    // memory address, wait counter, popped data and sticky error code.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= '0;
            data_q   <= '0;
            dst_q    <= '0;
            sp_q     <= '0;
            new_sp_q <= '0;
            addr_q   <= '0;
            tmo_cnt  <= '0;
            data_out <= '0;
            err_code <= ERR_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        data_q   <= data_in;
                        dst_q    <= dst;
                        err_code <= ERR_OK;
                    end
                end
                RD_SP: begin
                    sp_q <= sp_in;
                end
                CHECK: begin
                    tmo_cnt <= '0;
                    if (push_like) begin
                        new_sp_q <= sp_q - 32'd4;
                        addr_q   <= sp_q - 32'd4;
                        if (overflow) begin
                            err_code <= ERR_OVERFLOW;
                        end
                    end else begin
                        new_sp_q <= sp_q + 32'd4;
                        addr_q   <= sp_q;
                        if (underflow) begin
                            err_code <= ERR_UNDERFLOW;
                        end
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        if (!push_like) begin
                            data_out <= mem_rdata;
                        end
                    end else if (tmo_hit) begin
                        err_code <= ERR_TIMEOUT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state sequencing through check, access and commit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RD_SP;
                end
            end
            RD_SP: begin
                state_next = CHECK;
            end
            CHECK: begin
                if (push_like ? overflow : underflow) begin
                    state_next = ERR;
                end else begin
                    state_next = MEM;
                end
            end
            MEM: begin
                if (mem_ready) begin
                    state_next = WR_SP;
                end else if (tmo_hit) begin
                    state_next = ERR;
                end
            end
            WR_SP: begin
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            ERR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Per-state output decode; everything idles at zero outside its state.
    always_comb begin
        readSP       = 1'b0;
        writeSP      = 1'b0;
        write_dataSP = '0;
        writeReg     = 1'b0;
        dr           = '0;
        write_data   = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        done         = 1'b0;
        pc_load      = 1'b0;
        busy         = (state != IDLE);
        case (state)
            RD_SP: begin
                readSP = 1'b1;
            end
            MEM: begin
                mem_addr = addr_q;
                if (push_like) begin
                    mem_we    = 1'b1;
                    mem_wdata = data_q;
                end else begin
                    mem_re = 1'b1;
                end
            end
            WR_SP: begin
                writeSP      = 1'b1;
                write_dataSP = new_sp_q;
            end
            DONE: begin
                done = 1'b1;
                if (is_pop) begin
                    writeReg   = 1'b1;
                    dr         = dst_q;
                    write_data = data_out;
                end
                if (is_ret) begin
                    pc_load = 1'b1;
                end
            end
            ERR: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Multi-cycle sequencer for PUSH/POP/CALL/RET stack operations.
- Drives the register bank's SP read/write controls (readSP, writeSP, write_dataSP) and its general write port for POP results.
- Drives a single-port data-memory request interface with a ready handshake.
- Sits between the instruction decoder and the register bank/memory. The stack is full-descending, grows downward, in 4-byte words.

Parameters:
- STACK_TOP, 32'h0000_0100, SP value of an empty stack; pop or ret is illegal when SP >= STACK_TOP.
- STACK_LIMIT, 32'h0000_00F0, lowest legal SP; push or call is illegal when SP-4 < STACK_LIMIT.
- MEM_TIMEOUT, 15, maximum MEM-state cycles waiting for mem_ready before abort.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; asserting it (0) clears all state immediately.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  2  operation: 00 PUSH, 01 POP, 10 CALL, 11 RET; captured with start.
- data_in  in  32  value to push (PUSH) or return address (CALL); captured with start.
- dst  in  5  POP destination register; captured with start.
- sp_in  in  32  SP value from the register bank (read_data1 while readSP=1).
- readSP  out  1  selects SP onto register-bank read port 1.
- writeSP  out  1  SP write enable (one cycle).
- write_dataSP  out  32  new SP value.
- writeReg  out  1  register write enable (POP only, one cycle).
- dr  out  5  register write address.
- write_data  out  32  register write data.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_we  out  1  memory write request.
- mem_re  out  1  memory read request.
- mem_rdata  in  32  memory read data, valid when mem_ready=1.
- mem_ready  in  1  memory completion.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse (success or error).
- pc_load  out  1  one-cycle pulse on successful RET.
- data_out  out  32  popped value; held until the next accepted start.
- err_code  out  2  00 ok, 01 overflow, 10 underflow, 11 timeout; held until the next accepted start.

Behaviour:
- States: IDLE, RD_SP, CHECK, MEM, WR_SP, DONE, ERR.
- Reset values: all outputs 0, state IDLE, timeout counter 0. Reset mid-operation aborts immediately: no further writeSP, writeReg, mem_we or mem_re. The register bank holds whatever was last committed.
- IDLE: on start=1, capture op, data_in and dst; clear err_code; go to RD_SP. If start=0, stay in IDLE.
- RD_SP: readSP=1; register sp_in into sp_q; go to CHECK.
- CHECK, for PUSH/CALL:
  - new_sp = sp_q - 4, 32-bit modular.
  - If sp_q < STACK_LIMIT+4 (compare without wrap; SP=0 counts as overflow): err_code=01, go to ERR.
  - Else mem_addr = new_sp and mem_wdata = data_in_q; go to MEM.
- CHECK, for POP/RET:
  - If sp_q >= STACK_TOP: err_code=10, go to ERR.
  - Else mem_addr = sp_q and new_sp = sp_q + 4; go to MEM.
- MEM:
  - mem_we (PUSH/CALL) or mem_re (POP/RET) is held high, and mem_addr/mem_wdata held stable, until mem_ready=1.
  - mem_ready=1 in the first MEM cycle counts as zero wait states. On mem_ready, latch mem_rdata into data_out (reads only) and go to WR_SP.
  - Counter increments every MEM cycle without ready. When the count reaches MEM_TIMEOUT, drop the request, set err_code=11, go to ERR; SP is unchanged.
  - mem_ready outside MEM is ignored.
- WR_SP: writeSP=1, write_dataSP=new_sp, one cycle; go to DONE.
- DONE:
  - done=1.
  - POP: also writeReg=1, dr=dst_q, write_data=data_out. Because this follows WR_SP, POP into r31 leaves SP equal to the popped value.
  - RET: also pc_load=1.
  - Go to IDLE.
- ERR: done=1; no writeSP, writeReg or memory request; go to IDLE.
- Latency (start high in cycle 0, zero wait states): readSP in cycle 1, mem request in cycle 3, writeSP in cycle 4, done in cycle 5. Each wait state adds one cycle. Error detected in CHECK gives done in cycle 3.
- start while busy is ignored; there is no queueing.
- Back-to-back: start sampled in the IDLE cycle right after DONE is accepted.
- CALL behaves as PUSH of data_in; RET behaves as POP without a register write.

Test Plan:
- PUSH, sp_in=0x100, data_in=0xDEADBEEF, mem_ready tied 1 -> cycle 3: mem_we=1, mem_addr=0xFC, mem_wdata=0xDEADBEEF; cycle 4: writeSP=1, write_dataSP=0xFC; cycle 5: done=1, err_code=00.
- POP, dst=5, sp_in=0xFC, mem_rdata=0x1234 with 3 wait states -> mem_re held 4 cycles at mem_addr=0xFC; write_dataSP=0x100; DONE: writeReg=1, dr=5, write_data=0x1234, done at cycle 8.
- PUSH with sp_in=0xF0 (new SP 0xEC < 0xF0) -> err_code=01, done at cycle 3, mem_we and writeSP never asserted. POP with sp_in=0x100 -> err_code=10, same timing.
- RET, sp_in=0xF8, mem_rdata=0x40 -> data_out=0x40, pc_load one-cycle pulse together with done, write_dataSP=0xFC, writeReg stays 0.
- POP with mem_ready held 0 -> mem_re high for exactly 15 cycles, then err_code=11, done=1, writeSP never asserted. start pulsed mid-operation is ignored.
- reset driven low during MEM of a PUSH -> all outputs 0 asynchronously, no writeSP. After release, a new PUSH with sp_in=0x100 completes normally with write_dataSP=0xFC.
